// File: rtl/regfile_write_ctrl_if.sv
// Write-port bundle between the WB stage / multi-cycle unit and the register-file write controller.
// master = pipeline side, slave = controller.
interface regfile_write_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic              mc_pend_valid;
  logic [ADDR_W-1:0] mc_pend_addr;
  logic              wb_stall;
  logic              init_done;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_addr_rd;
  logic [DATA_W-1:0] rf_data_rd;

  modport master (
    output wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
    input  mc_ready, mc_pend_valid, mc_pend_addr, wb_stall, init_done,
           rf_write_enable, rf_addr_rd, rf_data_rd
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
    output mc_ready, mc_pend_valid, mc_pend_addr, wb_stall, init_done,
           rf_write_enable, rf_addr_rd, rf_data_rd
  );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port owner: zero-fills x1..x31 after reset, then arbitrates between
// the WB stage and a one-entry multi-cycle result buffer with starvation-driven stall.
module regfile_write_ctrl #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clock,
  input logic                reset_n,
  regfile_write_ctrl_if.slave bus
);

  localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [AgeW-1:0]   AgeMax   = AgeW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [AgeW-1:0]   age_q, age_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              init_done_q, init_done_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              mc_ready;
  logic              wb_hit;
  logic              drain;

  assign mc_ready = (state_q == StRun) && !buf_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    age_d       = age_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    init_done_d = init_done_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    wb_hit      = 1'b0;
    drain       = 1'b0;

    unique case (state_q)
      StInit: begin
        rf_we_d   = 1'b1;
        rf_addr_d = cnt_q;
        rf_data_d = '0;
        if (cnt_q == LastAddr) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        // Writes to x0 are dropped so the slot can drain the buffer instead.
        wb_hit = bus.wb_valid && (bus.wb_addr != '0);
        drain  = !wb_hit && buf_valid_q;
        if (wb_hit) begin
          rf_we_d   = 1'b1;
          rf_addr_d = bus.wb_addr;
          rf_data_d = bus.wb_data;
        end else if (drain) begin
          rf_we_d     = 1'b1;
          rf_addr_d   = buf_addr_q;
          rf_data_d   = buf_data_q;
          buf_valid_d = 1'b0;
          buf_addr_d  = '0;
        end

        if (buf_valid_q && !drain) begin
          age_d = (age_q >= AgeMax) ? AgeMax : age_q + 1'b1;
        end else begin
          age_d = '0;
        end

        // Fill only while empty, so a fill never coincides with a drain.
        if (mc_ready && bus.mc_valid && (bus.mc_addr != '0)) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = bus.mc_addr;
          buf_data_d  = bus.mc_data;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      cnt_q       <= ADDR_W'(1);
      age_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      init_done_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      age_q       <= age_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      init_done_q <= init_done_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
    end
  end

  assign bus.mc_ready        = mc_ready;
  assign bus.mc_pend_valid   = buf_valid_q;
  assign bus.mc_pend_addr    = buf_addr_q;
  assign bus.wb_stall        = (state_q == StInit) || (age_q >= AgeMax);
  assign bus.init_done       = init_done_q;
  assign bus.rf_write_enable = rf_we_q;
  assign bus.rf_addr_rd      = rf_addr_q;
  assign bus.rf_data_rd      = rf_data_q;

endmodule
